// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one simple-bus slave port between N_MASTERS masters,
// with a watchdog that force-terminates a hung slave access with an error pulse.
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_MASTERS-1:0]          i_m_bus_en,
  input  logic [N_MASTERS-1:0]          i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0]     i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0]     i_m_wr_data,
  input  logic [N_MASTERS*(XLEN/8)-1:0] i_m_byte_en,
  output logic [N_MASTERS-1:0]          o_m_ack,
  output logic [N_MASTERS-1:0]          o_m_err,
  output logic [XLEN-1:0]               o_m_rd_data,
  output logic                          o_s_bus_en,
  output logic                          o_s_wr_en,
  output logic [XLEN-1:0]               o_s_addr,
  output logic [XLEN-1:0]               o_s_wr_data,
  output logic [XLEN/8-1:0]             o_s_byte_en,
  input  logic                          i_s_ack,
  input  logic [XLEN-1:0]               i_s_rd_data
);

  localparam int GW = $clog2(N_MASTERS);
  localparam int BW = XLEN / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_next;
  logic [GW-1:0]        grant, last_grant, pick;
  logic                 pick_valid;
  logic [N_MASTERS-1:0] ack_mask, eligible;
  logic [CW-1:0]        count;
  logic                 timeout_hit, done;
  int                   idx;

  // Descending walk so the last hit is the nearest index after last_grant.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    eligible   = i_m_bus_en & ~ack_mask;
    for (int off = N_MASTERS; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % N_MASTERS;
      if (eligible[idx]) begin
        pick       = GW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (count == CW'(TIMEOUT - 1));
  assign done        = (state == BUSY) && (i_s_ack || timeout_hit);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = BUSY;
      BUSY:    if (done)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A real slave ack takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    o_m_ack     = '0;
    o_m_err     = '0;
    o_m_rd_data = '0;
    if (state == BUSY) begin
      if (i_s_ack) begin
        o_m_ack[grant] = 1'b1;
        o_m_rd_data    = i_s_rd_data;
      end else if (timeout_hit) begin
        o_m_ack[grant] = 1'b1;
        o_m_err[grant] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GW'(N_MASTERS - 1);
      ack_mask    <= '0;
      count       <= '0;
      o_s_bus_en  <= 1'b0;
      o_s_wr_en   <= 1'b0;
      o_s_addr    <= '0;
      o_s_wr_data <= '0;
      o_s_byte_en <= '0;
    end else begin
      state    <= state_next;
      ack_mask <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant       <= pick;
            last_grant  <= pick;
            o_s_bus_en  <= 1'b1;
            o_s_wr_en   <= i_m_wr_en[pick];
            o_s_addr    <= i_m_addr[pick*XLEN +: XLEN];
            o_s_wr_data <= i_m_wr_data[pick*XLEN +: XLEN];
            o_s_byte_en <= i_m_byte_en[pick*BW +: BW];
            count       <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            o_s_bus_en      <= 1'b0;
            ack_mask[grant] <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter (2 masters, 32-bit, TIMEOUT=8) plus a
// hand-written asynchronous-reset sequence.
module tb_bus_arbiter;

  localparam logic [31:0] WDATA0 = 32'hAAAA_AAAA;
  localparam logic [3:0]  BE0    = 4'hF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [1:0]  i_m_bus_en = '0, i_m_wr_en = '0;
  logic [63:0] i_m_addr = '0, i_m_wr_data = '0;
  logic [7:0]  i_m_byte_en = '0;
  logic [1:0]  o_m_ack, o_m_err;
  logic [31:0] o_m_rd_data;
  logic        o_s_bus_en, o_s_wr_en;
  logic [31:0] o_s_addr, o_s_wr_data;
  logic [3:0]  o_s_byte_en;
  logic        i_s_ack = 1'b0;
  logic [31:0] i_s_rd_data = '0;

  int applied = 0;
  int miscompares = 0;

  bus_arbiter #(.N_MASTERS(2), .XLEN(32), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m_bus_en(i_m_bus_en), .i_m_wr_en(i_m_wr_en), .i_m_addr(i_m_addr),
    .i_m_wr_data(i_m_wr_data), .i_m_byte_en(i_m_byte_en),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_rd_data(o_m_rd_data),
    .o_s_bus_en(o_s_bus_en), .o_s_wr_en(o_s_wr_en), .o_s_addr(o_s_addr),
    .o_s_wr_data(o_s_wr_data), .o_s_byte_en(o_s_byte_en),
    .i_s_ack(i_s_ack), .i_s_rd_data(i_s_rd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        rst_first;
    logic [1:0]  bus_en, wr_en;
    logic [31:0] addr0, addr1, wdata1;
    logic [3:0]  be1;
    logic        s_ack;
    logic [31:0] s_rd;
    logic        e_bus_en, e_wr_en;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic [1:0]  e_ack, e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rf, input logic [1:0] be, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1,
                     input logic [3:0] bye1, input logic sa, input logic [31:0] srd,
                     input logic ebus, input logic ewe, input logic [31:0] eaddr,
                     input logic [31:0] ewd, input logic [3:0] ebe, input logic [1:0] eack,
                     input logic [1:0] eerr, input logic [31:0] erd);
    vec_t v;
    v.name = name; v.rst_first = rf; v.bus_en = be; v.wr_en = we;
    v.addr0 = a0; v.addr1 = a1; v.wdata1 = wd1; v.be1 = bye1;
    v.s_ack = sa; v.s_rd = srd; v.e_bus_en = ebus; v.e_wr_en = ewe;
    v.e_addr = eaddr; v.e_wdata = ewd; v.e_be = ebe;
    v.e_ack = eack; v.e_err = eerr; v.e_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_m_bus_en = '0; i_m_wr_en = '0; i_s_ack = 1'b0; i_s_rd_data = '0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    i_m_bus_en  = v.bus_en;
    i_m_wr_en   = v.wr_en;
    i_m_addr    = {v.addr1, v.addr0};
    i_m_wr_data = {v.wdata1, WDATA0};
    i_m_byte_en = {v.be1, BE0};
    i_s_ack     = v.s_ack;
    i_s_rd_data = v.s_rd;
  endtask

  // Slave-side address/data fields are only meaningful while a request is presented.
  task automatic check_output(input vec_t v);
    check({v.name, ".s_bus_en"}, 32'(o_s_bus_en), 32'(v.e_bus_en));
    check({v.name, ".m_ack"}, 32'(o_m_ack), 32'(v.e_ack));
    check({v.name, ".m_err"}, 32'(o_m_err), 32'(v.e_err));
    check({v.name, ".m_rd_data"}, o_m_rd_data, v.e_rd);
    if (v.e_bus_en) begin
      check({v.name, ".s_wr_en"}, 32'(o_s_wr_en), 32'(v.e_wr_en));
      check({v.name, ".s_addr"}, o_s_addr, v.e_addr);
      check({v.name, ".s_wr_data"}, o_s_wr_data, v.e_wdata);
      check({v.name, ".s_byte_en"}, 32'(o_s_byte_en), 32'(v.e_be));
    end
  endtask

  initial begin
    // Single master 0 read, slave acks two cycles after the request appears.
    add("t1_idle", 1, 2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t1_busy1", 0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0,           1, 0, 32'h100, WDATA0, BE0, 2'b00, 2'b00, 0);
    add("t1_busy2", 0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 0, 0,           1, 0, 32'h100, WDATA0, BE0, 2'b00, 2'b00, 0);
    add("t1_ack", 0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF,  1, 0, 32'h100, WDATA0, BE0, 2'b01, 2'b00, 32'hDEADBEEF);
    add("t1_done", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Both masters held after reset: grants alternate 0,1,0,1 with one idle cycle between.
    add("t2_arb0", 1, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t2_g0a", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 1, 32'h11,    1, 0, 32'hA0, WDATA0, BE0, 2'b01, 2'b00, 32'h11);
    add("t2_gap1", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t2_g1a", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 1, 32'h22,    1, 0, 32'hB0, 0, 0, 2'b10, 2'b00, 32'h22);
    add("t2_gap2", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t2_g0b", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 1, 32'h33,    1, 0, 32'hA0, WDATA0, BE0, 2'b01, 2'b00, 32'h33);
    add("t2_gap3", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t2_g1b", 0, 2'b11, 2'b00, 32'hA0, 32'hB0, 0, 0, 1, 32'h44,    1, 0, 32'hB0, 0, 0, 2'b10, 2'b00, 32'h44);
    add("t2_done", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Master 1 write whose inputs change while BUSY; slave side keeps the latched values.
    add("t3_idle", 0, 2'b10, 2'b10, 0, 32'h200, 32'h12345678, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t3_busy1", 0, 2'b10, 2'b00, 0, 32'h204, 32'hFFFFFFFF, 4'hF, 0, 0,   1, 1, 32'h200, 32'h12345678, 4'b0011, 2'b00, 2'b00, 0);
    add("t3_busy2", 0, 2'b10, 2'b00, 0, 32'h208, 32'h0, 4'h0, 0, 0,          1, 1, 32'h200, 32'h12345678, 4'b0011, 2'b00, 2'b00, 0);
    add("t3_ack", 0, 2'b10, 2'b00, 0, 32'h20C, 32'h1, 4'h1, 1, 32'h5555,     1, 1, 32'h200, 32'h12345678, 4'b0011, 2'b10, 2'b00, 32'h5555);
    add("t3_done", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Watchdog expiry in BUSY cycle 8, then a normal grant to master 1.
    add("t4_idle", 0, 2'b01, 2'b00, 32'h300, 0, 0, 0, 0, 32'h9999,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 1; i <= 7; i++)
      add($sformatf("t4_busy%0d", i), 0, 2'b01, 2'b00, 32'h300, 0, 0, 0, 0, 32'h9999,
          1, 0, 32'h300, WDATA0, BE0, 2'b00, 2'b00, 0);
    add("t4_timeout", 0, 2'b01, 2'b00, 32'h300, 0, 0, 0, 0, 32'h9999, 1, 0, 32'h300, WDATA0, BE0, 2'b01, 2'b01, 0);
    add("t4_next_arb", 0, 2'b10, 2'b00, 0, 32'h400, 0, 0, 0, 0,       0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t4_next_ack", 0, 2'b10, 2'b00, 0, 32'h400, 0, 0, 1, 32'h77,  1, 0, 32'h400, 0, 0, 2'b10, 2'b00, 32'h77);
    add("t4_done", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Slave ack landing exactly on the watchdog cycle, then a stale request that must be masked.
    add("t5_idle", 0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int i = 1; i <= 7; i++)
      add($sformatf("t5_busy%0d", i), 0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,
          1, 0, 32'h500, WDATA0, BE0, 2'b00, 2'b00, 0);
    add("t5_ack_at_timeout", 0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 1, 32'hCAFEF00D,
        1, 0, 32'h500, WDATA0, BE0, 2'b01, 2'b00, 32'hCAFEF00D);
    add("t5_stale_req", 0, 2'b01, 2'b00, 32'h500, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    add("t5_no_regrant", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 2'b00, 2'b00, 0);

    // Reset state.
    i_rst = 1'b0;
    #12;
    check("rst.s_bus_en", 32'(o_s_bus_en), 0);
    check("rst.s_wr_en", 32'(o_s_wr_en), 0);
    check("rst.s_addr", o_s_addr, 0);
    check("rst.s_wr_data", o_s_wr_data, 0);
    check("rst.s_byte_en", 32'(o_s_byte_en), 0);
    check("rst.m_ack", 32'(o_m_ack), 0);
    check("rst.m_err", 32'(o_m_err), 0);
    check("rst.m_rd_data", o_m_rd_data, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    foreach (vecs[k]) begin
      if (vecs[k].rst_first) do_reset();
      @(posedge i_clk);
      #1;
      apply_stimulus(vecs[k]);
      #1;
      check_output(vecs[k]);
    end

    // Asynchronous reset mid-BUSY: everything drops at once and no ack escapes.
    @(posedge i_clk);
    #1;
    i_m_bus_en = 2'b10;
    i_m_addr   = {32'h600, 32'h0};
    i_s_ack    = 1'b0;
    @(posedge i_clk);
    #1;
    check("t6_busy.s_bus_en", 32'(o_s_bus_en), 1);
    check("t6_busy.s_addr", o_s_addr, 32'h600);
    #2;
    i_s_ack     = 1'b1;
    i_s_rd_data = 32'h1234;
    i_rst       = 1'b0;
    #1;
    check("t6_rst.s_bus_en", 32'(o_s_bus_en), 0);
    check("t6_rst.s_addr", o_s_addr, 0);
    check("t6_rst.m_ack", 32'(o_m_ack), 0);
    check("t6_rst.m_err", 32'(o_m_err), 0);
    check("t6_rst.m_rd_data", o_m_rd_data, 0);
    @(posedge i_clk);
    #1;
    check("t6_held.s_bus_en", 32'(o_s_bus_en), 0);
    i_s_ack    = 1'b0;
    i_m_bus_en = 2'b11;
    i_m_addr   = {32'h800, 32'h700};
    i_rst      = 1'b1;
    @(posedge i_clk);
    #1;
    check("t6_first.s_bus_en", 32'(o_s_bus_en), 1);
    check("t6_first.s_addr", o_s_addr, 32'h700);
    i_s_ack = 1'b1;
    #1;
    check("t6_first.m_ack", 32'(o_m_ack), 32'b01);
    @(posedge i_clk);
    #1;
    i_s_ack    = 1'b0;
    i_m_bus_en = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one simple-bus slave port (bus_en/wr_en/addr/wr_data/byte_en, ack/rd_data) between N_MASTERS bus masters.
- Typical masters: instruction/data bus adapters of several harts, or a debug/DMA master.
- Sits between the per-core bus adapters and the memory/peripheral interconnect.
- Adds a transaction watchdog that terminates a hung slave access with an error flag.

Parameters:
- N_MASTERS, 2, number of requesting masters (>=2).
- XLEN, 32, address/data width.
- TIMEOUT, 255, max BUSY cycles before forced termination; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_m_bus_en  in  N_MASTERS  per-master request; held high until that master's ack
- i_m_wr_en  in  N_MASTERS  per-master write (1) / read (0)
- i_m_addr  in  N_MASTERS*XLEN  per-master address, master k at [k*XLEN +: XLEN]
- i_m_wr_data  in  N_MASTERS*XLEN  per-master write data
- i_m_byte_en  in  N_MASTERS*(XLEN/8)  per-master byte enables
- o_m_ack  out  N_MASTERS  one-cycle completion pulse to the granted master
- o_m_err  out  N_MASTERS  one-cycle error pulse, coincident with o_m_ack on timeout
- o_m_rd_data  out  XLEN  read data shared by all masters; valid only with the owner's o_m_ack
- o_s_bus_en  out  1  slave request
- o_s_wr_en  out  1  slave write enable
- o_s_addr  out  XLEN  slave address
- o_s_wr_data  out  XLEN  slave write data
- o_s_byte_en  out  XLEN/8  slave byte enables
- i_s_ack  in  1  slave completion
- i_s_rd_data  in  XLEN  slave read data

Behaviour:
Reset (i_rst=0, asynchronous):
- state=IDLE; all o_s_* = 0; o_m_ack = 0; o_m_err = 0; o_m_rd_data = 0; watchdog counter = 0.
- last_grant = N_MASTERS-1, so master 0 has first priority.
- Reset asserted mid-transaction aborts it with no ack to the master; the slave sees o_s_bus_en drop immediately.

States: IDLE, BUSY.

IDLE:
- Eligible set = i_m_bus_en with the master acked in the previous cycle masked out (one-cycle mask, because masters drop their request the cycle after ack).
- If eligible is non-empty, grant the first eligible index searching upward from last_grant+1, wrapping modulo N_MASTERS.
- At the clock edge: register grant, set last_grant, latch the granted master's wr_en/addr/wr_data/byte_en into o_s_*, set o_s_bus_en=1, clear the counter, go to BUSY.
- Arbitration latency: request high in cycle t gives o_s_bus_en high in cycle t+1 (when eligible and not blocked).

BUSY:
- o_s_* held stable from latched values; later master input changes are ignored.
- Counter increments each cycle.
- i_s_ack=1: same cycle (combinational), o_m_ack[grant]=1 and o_m_rd_data=i_s_rd_data. Next edge: o_s_bus_en=0, go to IDLE, set the ack mask to grant.
- TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack: same cycle, o_m_ack[grant]=1, o_m_err[grant]=1, o_m_rd_data=0. Next edge as for ack.
- i_s_ack and timeout in the same cycle: ack wins, o_m_err=0.
- o_m_ack/o_m_err to non-granted masters are always 0.
- o_m_rd_data = 0 whenever no ack is issued.

Minimum turnaround: ack in cycle t, next grant visible on o_s_bus_en at t+2. The bus is never idle longer than this while requests are pending.

Fairness:
- A continuously requesting master waits at most N_MASTERS-1 transactions.
- The mask guarantees no back-to-back double service caused by a stale request.

Counter width: $clog2(TIMEOUT+1). No wrap occurs because the transaction terminates at TIMEOUT.

Test Plan:
- Single master 0 read, addr 0x100, slave acks 2 cycles after o_s_bus_en with rd_data 0xDEADBEEF -> o_s_bus_en high at t+1, o_m_ack[0] pulse with o_m_rd_data 0xDEADBEEF, o_m_ack[1]=0.
- Masters 0 and 1 request simultaneously after reset, both held -> grants in order 0,1,0,1. Slave observes the matching addrs; each grant is separated by exactly one IDLE cycle.
- Master 1 write, wr_data 0x12345678, byte_en 4'b0011, master 1 changes addr while BUSY -> o_s_addr/o_s_wr_data/o_s_byte_en stay at the latched values until ack.
- TIMEOUT=8, slave never acks -> o_m_ack[g] and o_m_err[g] pulse together in BUSY cycle 8; o_s_bus_en low next cycle; next request is granted normally.
- i_s_ack arrives on exactly the timeout cycle -> o_m_ack=1, o_m_err=0, rd_data passed through.
- i_rst driven low asynchronously mid-BUSY -> all outputs 0 immediately, no ack issued. After release, master 0 is granted first.
